// File: rtl/ovi_vector_responder.sv
// Vector-unit responder: accepts instructions, retires arithmetic ops after a fixed latency and
// streams counted store packets framed by sync pulses. Optional opcode screening: OVI_RESPONDER_ILLEGAL_CHECK_EN.
module ovi_vector_responder #(
   parameter int VL_WIDTH      = 15,
   parameter int DATA_WIDTH    = 512,
   parameter int ARITH_LATENCY = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  issue_valid_i,
   output logic                  issue_ready_o,
   input  logic [31:0]           issue_instr_i,
   input  logic [VL_WIDTH-1:0]   issue_vl_i,
   input  logic [1:0]            issue_sew_i,
   output logic                  sync_start_o,
   output logic                  store_valid_o,
   input  logic                  store_ready_i,
   output logic [DATA_WIDTH-1:0] store_data_o,
   output logic                  sync_end_o,
   output logic                  completed_valid_o,
   output logic                  completed_illegal_o
);

   localparam int NW   = VL_WIDTH + 7;
   localparam int SUMW = NW + $clog2(DATA_WIDTH) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_EXECUTE, S_STORE_SYNC, S_STORE_DATA, S_STORE_END, S_COMPLETE
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [NW-1:0]         pkt_q, pkt_d;
   logic [31:0]           instr_q, instr_d;
   logic [VL_WIDTH-1:0]   vl_q, vl_d;
   logic [1:0]            sew_q, sew_d;
   logic                  illegal_q, illegal_d;

   logic                  accept;
   logic                  accept_store;
   logic                  accept_illegal;
   logic [SUMW-1:0]       total_bits;
   logic [NW-1:0]         num_pkts;
   logic [31:0]           pkt_word;
   logic                  unused_instr;

   assign unused_instr = ^instr_q;

   // Ready is also gated by reset so the port reads 0 while reset is held.
   assign issue_ready_o = rst_ni && (state_q == S_IDLE);
   assign accept        = issue_valid_i && issue_ready_o;
   assign accept_store  = (issue_instr_i[6:0] == 7'h27);

`ifdef OVI_RESPONDER_ILLEGAL_CHECK_EN
   assign accept_illegal = !(issue_instr_i[6:0] == 7'h57 || issue_instr_i[6:0] == 7'h07 ||
                             issue_instr_i[6:0] == 7'h27) ||
                           (accept_store && issue_sew_i == 2'd3 && issue_vl_i != '0);
`else
   assign accept_illegal = 1'b0;
`endif

   // Packet count is the ceiling of total store bits over the packet width.
   assign total_bits = SUMW'(vl_q) << ({1'b0, sew_q} + 3'd3);
   assign num_pkts   = NW'((total_bits + SUMW'(DATA_WIDTH - 1)) / SUMW'(DATA_WIDTH));
   assign pkt_word   = 32'(pkt_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pkt_q     <= '0;
         instr_q   <= '0;
         vl_q      <= '0;
         sew_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pkt_q     <= pkt_d;
         instr_q   <= instr_d;
         vl_q      <= vl_d;
         sew_q     <= sew_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      cnt_d             = cnt_q;
      pkt_d             = pkt_q;
      instr_d           = instr_q;
      vl_d              = vl_q;
      sew_d             = sew_q;
      illegal_d         = illegal_q;
      sync_start_o      = 1'b0;
      store_valid_o     = 1'b0;
      sync_end_o        = 1'b0;
      completed_valid_o = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               instr_d   = issue_instr_i;
               vl_d      = issue_vl_i;
               sew_d     = issue_sew_i;
               illegal_d = accept_illegal;
               cnt_d     = 4'd1;
               pkt_d     = '0;
               if (accept_illegal)    state_d = S_COMPLETE;
               else if (accept_store) state_d = S_STORE_SYNC;
               else                   state_d = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            // cnt_q counts cycles since acceptance; retire when it hits the latency.
            if (cnt_q == 4'(ARITH_LATENCY)) begin
               completed_valid_o = 1'b1;
               cnt_d             = '0;
               state_d           = S_IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_STORE_SYNC: begin
            sync_start_o = 1'b1;
            state_d      = (num_pkts == '0) ? S_STORE_END : S_STORE_DATA;
         end
         S_STORE_DATA: begin
            store_valid_o = 1'b1;
            if (store_ready_i) begin
               if (pkt_q == num_pkts - NW'(1)) begin
                  pkt_d   = '0;
                  state_d = S_STORE_END;
               end else begin
                  pkt_d = pkt_q + NW'(1);
               end
            end
         end
         S_STORE_END: begin
            sync_end_o = 1'b1;
            state_d    = S_COMPLETE;
         end
         S_COMPLETE: begin
            completed_valid_o = 1'b1;
            state_d           = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign completed_illegal_o = (state_q == S_COMPLETE) && illegal_q;

   // Payload is the packet index replicated in 32-bit lanes; zero outside the data phase.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_data
         assign store_data_o[gi] = (state_q == S_STORE_DATA) && pkt_word[gi % 32];
      end
   endgenerate

endmodule

// File: tb/tb_ovi_vector_responder.sv
// Self-checking bench for ovi_vector_responder: directed scenarios plus random instruction mix
// compared cycle by cycle against a transaction-level expectation model.
module tb_ovi_vector_responder;

   localparam int VLW = 15;
   localparam int DW  = 512;
   localparam int LAT = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           issue_valid = 1'b0;
   logic           issue_ready;
   logic [31:0]    issue_instr = '0;
   logic [VLW-1:0] issue_vl = '0;
   logic [1:0]     issue_sew = '0;
   logic           sync_start;
   logic           store_valid;
   logic           store_ready = 1'b0;
   logic [DW-1:0]  store_data;
   logic           sync_end;
   logic           cv;
   logic           ci;

   int checks   = 0;
   int failures = 0;
   int txn      = 0;

   always #5 clk = ~clk;

   ovi_vector_responder #(
      .VL_WIDTH(VLW), .DATA_WIDTH(DW), .ARITH_LATENCY(LAT)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
      .issue_instr_i(issue_instr), .issue_vl_i(issue_vl), .issue_sew_i(issue_sew),
      .sync_start_o(sync_start), .store_valid_o(store_valid), .store_ready_i(store_ready),
      .store_data_o(store_data), .sync_end_o(sync_end),
      .completed_valid_o(cv), .completed_illegal_o(ci)
   );

   function automatic logic [DW-1:0] pkt(input int k);
      logic [DW-1:0] d;
      d = '0;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = k;
      return d;
   endfunction

   function automatic bit model_illegal(input logic [31:0] ins, input int vl, input int sew);
`ifdef OVI_RESPONDER_ILLEGAL_CHECK_EN
      logic [6:0] op;
      op = ins[6:0];
      return !(op == 7'h57 || op == 7'h07 || op == 7'h27) || (op == 7'h27 && sew == 3 && vl > 0);
`else
      return 1'b0;
`endif
   endfunction

   // flags = {issue_ready, sync_start, store_valid, sync_end, completed_valid, completed_illegal}
   task automatic check_now(input string tag, input logic [5:0] ef, input logic [DW-1:0] ed);
      logic [5:0] of;
      of = {issue_ready, sync_start, store_valid, sync_end, cv, ci};
      checks++;
      assert (of === ef) else begin
         failures++;
         $error("FAIL %s flags observed=%b expected=%b t=%0t", tag, of, ef, $time);
      end
      checks++;
      assert (store_data === ed) else begin
         failures++;
         $error("FAIL %s data observed=%h expected=%h t=%0t", tag, store_data, ed, $time);
      end
   endtask

   task automatic expect_cycle(input string tag, input logic [5:0] ef, input logic [DW-1:0] ed);
      check_now(tag, ef, ed);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issues one instruction (caller is before the rising edge with the responder idle) and
   // walks the expected cycle sequence until the completion pulse.
   task automatic run_instr(input logic [31:0] ins, input int vl, input int sew,
                            input int fixed_stall, input int stall_pct);
      int n, k, dc;
      bit rdy;
      string kind;
      issue_valid = 1'b1;
      issue_instr = ins;
      issue_vl    = vl[VLW-1:0];
      issue_sew   = sew[1:0];
      expect_cycle("accept", 6'b100000, '0);
      // Busy-time inputs are garbage and must be ignored.
      issue_valid = 1'($urandom_range(0, 1));
      issue_instr = $urandom;
      issue_vl    = VLW'($urandom);
      issue_sew   = 2'($urandom);
      n = 0;
      if (model_illegal(ins, vl, sew)) begin
         kind = "illegal";
         issue_valid = 1'b0;
         expect_cycle("illegal_done", 6'b000011, '0);
      end else if (ins[6:0] == 7'h27) begin
         kind = "store";
         n = (vl * (8 << sew) + DW - 1) / DW;
         expect_cycle("sync_start", 6'b010000, '0);
         k  = 0;
         dc = 0;
         while (k < n && dc < 4000) begin
            rdy = (dc < fixed_stall) ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
            store_ready = rdy;
            expect_cycle("packet", 6'b001000, pkt(k));
            if (rdy) k++;
            dc++;
         end
         store_ready = 1'($urandom);
         issue_valid = 1'b0;
         expect_cycle("sync_end", 6'b000100, '0);
         expect_cycle("store_done", 6'b000010, '0);
         store_ready = 1'b0;
      end else begin
         kind = "arith";
         for (int c = 1; c <= LAT; c++) begin
            if (c == LAT) begin
               issue_valid = 1'b0;
               expect_cycle("arith_done", 6'b000010, '0);
            end else begin
               expect_cycle("arith_busy", 6'b000000, '0);
            end
         end
      end
      txn++;
      $display("txn %0d instr=%h vl=%0d sew=%0d kind=%s pkts=%0d", txn, ins, vl, sew, kind, n);
   endtask

   initial begin
      logic [31:0] ins;
      int sel;

      @(negedge clk);
      check_now("reset_state", 6'b000000, '0);
      rst_n = 1'b1;
      #1 check_now("release_ready", 6'b100000, '0);

      run_instr(32'h0200_0057, 8, 2, 0, 0);
      expect_cycle("ready_after_arith", 6'b100000, '0);
      run_instr(32'h0200_0027, 32, 2, 0, 0);
      run_instr(32'h0200_0027, 16, 3, 3, 0);
      run_instr(32'h0200_0027, 0, 1, 0, 0);
      run_instr(32'h0200_0033, 8, 0, 0, 0);
      run_instr(32'h0200_0007, 1, 0, 0, 0);
      expect_cycle("idle", 6'b100000, '0);

      // Reset asserted while packet 1 is on the bus.
      issue_valid = 1'b1;
      issue_instr = 32'h0200_0027;
      issue_vl    = VLW'(64);
      issue_sew   = 2'd2;
      expect_cycle("rst_accept", 6'b100000, '0);
      issue_valid = 1'b0;
      expect_cycle("rst_sync", 6'b010000, '0);
      store_ready = 1'b1;
      expect_cycle("rst_pkt0", 6'b001000, pkt(0));
      check_now("rst_pkt1", 6'b001000, pkt(1));
      #1 rst_n = 1'b0;
      #1 check_now("in_reset", 6'b000000, '0);
      store_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_now("in_reset_hold", 6'b000000, '0);
      rst_n = 1'b1;
      #1 check_now("after_release", 6'b100000, '0);
      run_instr(32'h0200_0057, 8, 2, 0, 0);

      for (int t = 0; t < 40; t++) begin
         sel = $urandom_range(0, 4);
         ins = $urandom;
         case (sel)
            0, 1: ins[6:0] = 7'h27;
            2:    ins[6:0] = 7'h57;
            3:    ins[6:0] = 7'h07;
            default: ;
         endcase
         for (int w = $urandom_range(0, 2); w > 0; w--) expect_cycle("idle", 6'b100000, '0);
         run_instr(ins, $urandom_range(0, 300), $urandom_range(0, 3), 0, $urandom_range(0, 60));
      end
      expect_cycle("final_idle", 6'b100000, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/ovi_vector_responder.md
OVI_VECTOR_RESPONDER -- requirements
Module: ovi_vector_responder

Interface
REQ-001 SHALL have parameter VL_WIDTH, default 15, vector-length field width.
REQ-002 SHALL have parameter DATA_WIDTH, default 512, store packet width in bits.
REQ-003 SHALL have parameter ARITH_LATENCY, default 4, accept-to-completion cycles for non-store instructions (legal range 1..15).
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous assertion, active-low.
REQ-006 SHALL have port ISSUE_VALID  input  1  core presents an instruction.
REQ-007 SHALL have port ISSUE_READY  output  1  responder can accept an instruction.
REQ-008 SHALL have port ISSUE_INSTR  input  32  instruction word.
REQ-009 SHALL have port ISSUE_VL  input  VL_WIDTH  element count.
REQ-010 SHALL have port ISSUE_SEW  input  2  element width code: 0=8, 1=16, 2=32, 3=64 bits.
REQ-011 SHALL have port SYNC_START  output  1  one-cycle pulse opening a store data transfer.
REQ-012 SHALL have port STORE_VALID  output  1  STORE_DATA holds a valid packet.
REQ-013 SHALL have port STORE_READY  input  1  core accepts the current packet.
REQ-014 SHALL have port STORE_DATA  output  DATA_WIDTH  store packet payload.
REQ-015 SHALL have port SYNC_END  output  1  one-cycle pulse closing a store transfer.
REQ-016 SHALL have port COMPLETED_VALID  output  1  one-cycle pulse: instruction retired.
REQ-017 SHALL have port COMPLETED_ILLEGAL  output  1  qualifies COMPLETED_VALID; instruction rejected.

Function
REQ-018 SHALL implement states IDLE, EXECUTE, STORE_SYNC, STORE_DATA, STORE_END, COMPLETE.
REQ-019 SHALL drive ISSUE_READY=1 only in IDLE; acceptance = ISSUE_VALID & ISSUE_READY; instr/vl/sew captured at acceptance; inputs ignored otherwise.
REQ-020 SHALL classify accepted instruction as store when ISSUE_INSTR[6:0]=7'h27, else arithmetic.
REQ-021 Arithmetic: IDLE->EXECUTE; COMPLETED_VALID pulses exactly ARITH_LATENCY cycles after acceptance cycle; return to IDLE in the pulse cycle, so ISSUE_READY=1 the following cycle.
REQ-022 Store: IDLE->STORE_SYNC; SYNC_START=1 in the cycle after acceptance; then STORE_DATA.
REQ-023 Packet count N = ceil(vl * (8<<sew) / DATA_WIDTH), computed in >=VL_WIDTH+7 bits without overflow.
REQ-024 In STORE_DATA: STORE_VALID=1; packet k (0-based) = k zero-extended to 32 bits, replicated across DATA_WIDTH; STORE_DATA held stable while STORE_VALID & !STORE_READY; k advances on handshake.
REQ-025 After handshake of packet N-1: STORE_END next cycle (SYNC_END=1), then COMPLETE (COMPLETED_VALID=1), then IDLE.
REQ-026 vl=0 store: N=0; STORE_SYNC proceeds directly to STORE_END; no STORE_VALID asserted.
REQ-027 STORE_READY held high SHALL give one packet per cycle, no bubbles.
REQ-028 SYNC_START, SYNC_END, COMPLETED_VALID SHALL never overlap and each be exactly one cycle.
REQ-029 COMPLETED_ILLEGAL SHALL be 0 whenever COMPLETED_VALID=0.

Reset
REQ-030 RST_N low SHALL force state IDLE, packet counter 0, latency counter 0, captured fields 0, immediately, including mid-transfer.
REQ-031 During reset outputs SHALL be: ISSUE_READY 0, all pulses 0, STORE_VALID 0, STORE_DATA 0, COMPLETED_ILLEGAL 0; ISSUE_READY=1 first cycle after release.

Configuration
REQ-032 Macro OVI_RESPONDER_ILLEGAL_CHECK_EN defined: instruction with ISSUE_INSTR[6:0] not in {7'h57, 7'h07, 7'h27} or ISSUE_SEW=3 with vl>0 on a store SHALL complete 1 cycle after acceptance with COMPLETED_VALID=1, COMPLETED_ILLEGAL=1, no sync/store activity.
REQ-033 Macro undefined: COMPLETED_ILLEGAL SHALL be constant 0; all non-store opcodes treated as arithmetic.

Verification
REQ-034 Arithmetic instr 32'h0200_0057, vl=8, sew=2, ARITH_LATENCY=4, accepted cycle 0 -> COMPLETED_VALID cycle 4 only, ISSUE_READY cycle 5.
REQ-035 Store 32'h0200_0027, vl=32, sew=2, STORE_READY=1 -> SYNC_START cycle 1, packets 0,1 cycles 2-3, SYNC_END cycle 4, COMPLETED_VALID cycle 5.
REQ-036 Store vl=16, sew=3, STORE_READY low cycles 2-4 -> packet 0 held stable 3 cycles, two packets total, completion after SYNC_END.
REQ-037 Store vl=0 -> SYNC_START, SYNC_END next cycle, COMPLETED_VALID next, STORE_VALID never high.
REQ-038 RST_N low during packet 1 of vl=64 sew=2 store -> all outputs 0 immediately; after release ISSUE_READY=1, new arithmetic completes normally.
REQ-039 With OVI_RESPONDER_ILLEGAL_CHECK_EN, instr opcode 7'h33 -> COMPLETED_VALID and COMPLETED_ILLEGAL both 1 at cycle 1; without macro, completion at cycle ARITH_LATENCY with ILLEGAL=0.
